// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic single-cycle master bridge between a core memory port
// and the system bus; stalls the pipeline until each access completes.
module wishbone_bus_if #(
  parameter int TO_W  = 8,
  parameter bit TO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_data_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = '1;
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t          state, state_nxt;
  logic [31:0]     rd_buf;
  logic [TO_W-1:0] to_cnt;
  logic            start, busy_flush, busy_ack, busy_to, stalled;

  always_comb begin
    start      = (state == IDLE) && cpu_ce_i && !flush_i;
    busy_flush = (state == BUSY) && flush_i;
    busy_ack   = (state == BUSY) && !flush_i && wishbone_ack_i;
    busy_to    = (state == BUSY) && !flush_i && !wishbone_ack_i
                 && TO_EN && (to_cnt == TO_MAX);
    stalled    = (stall_i != 6'd0);
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = 32'd0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          stallreq_o = cpu_ce_i && !flush_i;
          if (start) state_nxt = BUSY;
        end
        BUSY: begin
          if (busy_flush) begin
            state_nxt = IDLE;
          end else if (busy_ack || busy_to) begin
            state_nxt = stalled ? WAIT_FOR_STALL : IDLE;
            if (busy_ack && !wishbone_we_o) cpu_data_o = wishbone_data_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf;
          if (flush_i || !stalled) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bus outputs return to zero whenever a cycle ends, whatever the reason.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wishbone_addr_o <= 32'd0;
      wishbone_data_o <= 32'd0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= 4'd0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
      rd_buf          <= 32'd0;
      to_cnt          <= '0;
      bus_err_o       <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      if (start) begin
        wishbone_addr_o <= cpu_addr_i;
        wishbone_data_o <= cpu_data_i;
        wishbone_we_o   <= cpu_we_i;
        wishbone_sel_o  <= cpu_sel_i;
        wishbone_stb_o  <= 1'b1;
        wishbone_cyc_o  <= 1'b1;
        rd_buf          <= 32'd0;
        to_cnt          <= '0;
      end else if (busy_flush || busy_ack || busy_to) begin
        wishbone_addr_o <= 32'd0;
        wishbone_data_o <= 32'd0;
        wishbone_we_o   <= 1'b0;
        wishbone_sel_o  <= 4'd0;
        wishbone_stb_o  <= 1'b0;
        wishbone_cyc_o  <= 1'b0;
        if (busy_ack && !wishbone_we_o) rd_buf <= wishbone_data_i;
        if (busy_to) begin
          rd_buf    <= 32'd0;
          bus_err_o <= 1'b1;
        end
      end else if (state == BUSY) begin
        if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_ONE;
      end else if (state == WAIT_FOR_STALL && flush_i) begin
        rd_buf <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Self-checking bench for wishbone_bus_if: scripted slave, scoreboard queue
// of expected read data, timeout and asynchronous-reset scenarios.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i, cpu_ce_i, cpu_we_i, wishbone_ack_i;
  logic [31:0] cpu_data_i, cpu_addr_i, wishbone_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o, wishbone_addr_o, wishbone_data_o;
  logic        stallreq_o, bus_err_o, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o;
  logic [3:0]  wishbone_sel_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  wishbone_bus_if #(.TO_W(4), .TO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_data_i(cpu_data_i), .cpu_addr_i(cpu_addr_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One core access: `waits` unacked BUSY cycles, then an ack cycle; the
  // external stall (if any) is raised with the ack and held stall_n more cycles.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                           input int stall_n, input logic flush);
    logic [31:0] exp_d;
    int sr_cnt;
    sr_cnt = 0;
    exp_d  = we ? 32'd0 : rdata;
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata; cpu_sel_i = sel;
    sample();
    check("idle_stb", wishbone_stb_o, 0);
    check("idle_data", cpu_data_o, 0);
    sr_cnt += int'(stallreq_o);
    for (int w = 0; w <= waits; w++) begin
      tick();
      cpu_ce_i = 1'b0; cpu_data_i = 32'hFFFF_FFFF; cpu_addr_i = 32'hFFFF_FFFF;
      if (w == waits) begin
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = rdata;
        stall_i         = (stall_n > 0) ? 6'b001111 : 6'd0;
        flush_i         = flush;
        sb_q.push_back(flush ? 32'd0 : exp_d);
      end
      sample();
      check("busy_stb", wishbone_stb_o, 1);
      check("busy_cyc", wishbone_cyc_o, 1);
      check("busy_adr", wishbone_addr_o, addr);
      check("busy_dat", wishbone_data_o, wdata);
      check("busy_sel", {28'd0, wishbone_sel_o}, {28'd0, sel});
      check("busy_we", wishbone_we_o, we);
      sr_cnt += int'(stallreq_o);
      if (w == waits) check("ack_data", cpu_data_o, sb_q.pop_front());
      else            check("wait_data", cpu_data_o, 0);
    end
    check("stall_cycles", sr_cnt, waits + 1);
    tick();
    wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0BAD_F00D; flush_i = 1'b0;
    sample();
    check("end_stb", wishbone_stb_o, 0);
    check("end_cyc", wishbone_cyc_o, 0);
    check("end_adr", wishbone_addr_o, 0);
    check("end_err", bus_err_o, 0);
    check("end_sreq", stallreq_o, 0);
    if (stall_n > 0 && !flush) begin
      for (int k = 0; k < stall_n; k++) begin
        if (k > 0) begin tick(); sample(); end
        check("hold_data", cpu_data_o, exp_d);
        check("hold_sreq", stallreq_o, 0);
      end
      tick();
      stall_i = 6'd0;
      sample();
      check("release_data", cpu_data_o, exp_d);
    end else begin
      check("post_data", cpu_data_o, 0);
    end
    tick();
    stall_i = 6'd0;
    sample();
    check("idle_after", cpu_data_o, 0);
    check("idle_after_stb", wishbone_stb_o, 0);
  endtask

  task automatic do_timeout();
    int stb_n;
    logic done, prev_sr;
    stb_n = 0; done = 1'b0; prev_sr = 1'b1;
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500; cpu_sel_i = 4'hF;
    sample();
    check("to_req", stallreq_o, 1);
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      cpu_ce_i = 1'b0;
      sample();
      if (wishbone_stb_o) begin
        stb_n++;
        prev_sr = stallreq_o;
        if (bus_err_o) check("to_early_err", bus_err_o, 0);
      end else begin
        done = 1'b1;
        check("to_err", bus_err_o, 1);
        check("to_cyc", wishbone_cyc_o, 0);
        check("to_data", cpu_data_o, 0);
        check("to_sreq", stallreq_o, 0);
      end
    end
    check("to_done", done, 1);
    check("to_abort_sreq", prev_sr, 0);
    check("to_len", stb_n, 16);
    tick();
    sample();
    check("to_err_pulse", bus_err_o, 0);
  endtask

  task automatic do_reset_mid_busy();
    tick();
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600;
    tick();
    sample();
    check("rst_busy_stb", wishbone_stb_o, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_stb", wishbone_stb_o, 0);
    check("rst_cyc", wishbone_cyc_o, 0);
    check("rst_sreq", stallreq_o, 0);
    cpu_ce_i = 1'b0;
    tick();
    rst = 1'b0;
    sample();
    check("rst_rel_stb", wishbone_stb_o, 0);
    check("rst_rel_sreq", stallreq_o, 0);
    tick();
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h700;
    sample();
    check("rst_idle_req", stallreq_o, 1);
    tick();
    cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1357_9BDF;
    sample();
    check("rst_new_stb", wishbone_stb_o, 1);
    check("rst_new_adr", wishbone_addr_o, 32'h700);
    check("rst_new_data", cpu_data_o, 32'h1357_9BDF);
    tick();
    wishbone_ack_i = 1'b0;
    sample();
    check("rst_new_end", wishbone_stb_o, 0);
  endtask

  initial begin
    rst = 1'b1; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_data_i = 32'd0; cpu_addr_i = 32'd0; cpu_sel_i = 4'd0;
    wishbone_ack_i = 1'b0; wishbone_data_i = 32'd0;
    #12;
    check("reset_stb", wishbone_stb_o, 0);
    check("reset_cyc", wishbone_cyc_o, 0);
    check("reset_adr", wishbone_addr_o, 0);
    check("reset_err", bus_err_o, 0);
    check("reset_data", cpu_data_o, 0);
    check("reset_sreq", stallreq_o, 0);
    @(negedge clk);
    rst = 1'b0;

    do_access(1'b0, 32'h100, 32'd0,         4'hF, 0, 32'hDEADBEEF, 0, 1'b0);
    do_access(1'b1, 32'h200, 32'h12345678,  4'h3, 3, 32'h0BAD0BAD, 0, 1'b0);
    do_access(1'b0, 32'h300, 32'd0,         4'hF, 1, 32'hCAFE0001, 3, 1'b0);
    do_access(1'b0, 32'h400, 32'd0,         4'hF, 2, 32'h55AA55AA, 3, 1'b1);
    do_timeout();
    do_reset_mid_busy();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
